// File: rtl/cache_arb_pkg.sv
// Shared types for the two-requester cache-port arbiter.
// Holds the FSM encoding, the requester index type and the op encoding.
package cache_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

    typedef logic [0:0] req_idx_t;

    typedef enum logic {OP_READ, OP_WRITE} arb_op_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input req_idx_t idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/cache_arbiter_rr_pick.sv
// Round-robin winner selection: scan upward from the requester after 'last'.
// Purely combinational so the policy can grow to more requesters unchanged.
module rr_pick
    import cache_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] pending,
    input  req_idx_t           last,
    output logic               valid,
    output req_idx_t           winner
);

    req_idx_t cand;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = req_idx_t'((int'(last) + k) % NUM_REQ);
            if (!valid && pending[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares the single cache port between instruction fetch (0) and LSU (1),
// one transaction at a time, with a response-timeout watchdog.
//
// state | meaning
// IDLE  | waiting for cache_rdy and a pending request
// ISSUE | read/write strobe to the cache is high for this one cycle
// WAIT  | counting cycles until cache_valid or timeout
// RESP  | r_done high to the granted requester; request may change
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            r_ren,
    input  logic [NUM_REQ-1:0]            r_wen,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] r_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] r_din,
    output logic [NUM_REQ-1:0]            r_gnt,
    output logic [NUM_REQ-1:0]            r_done,
    output logic [DATA_WIDTH-1:0]         r_dout,
    output logic                          r_err,
    input  logic                          cache_rdy,
    input  logic                          cache_valid,
    input  logic [DATA_WIDTH-1:0]         cache_dout,
    output logic                          cache_ren,
    output logic                          cache_wen,
    output logic [ADDR_WIDTH-1:0]         cache_addr,
    output logic [DATA_WIDTH-1:0]         cache_din,
    output logic                          busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_t            state, state_nxt;
    req_idx_t              last, last_nxt;
    req_idx_t              gnt_idx, gnt_idx_nxt;
    req_idx_t              pick_idx;
    logic                  pick_valid;
    arb_op_t               op, op_nxt;
    logic [TW-1:0]         timer, timer_nxt;
    logic [NUM_REQ-1:0]    r_gnt_nxt, r_done_nxt;
    logic [DATA_WIDTH-1:0] r_dout_nxt, cache_din_nxt;
    logic [ADDR_WIDTH-1:0] cache_addr_nxt;
    logic                  r_err_nxt, cache_ren_nxt, cache_wen_nxt, busy_nxt;

    rr_pick u_rr_pick (
        .pending (r_ren | r_wen),
        .last    (last),
        .valid   (pick_valid),
        .winner  (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last       <= req_idx_t'(1);
            gnt_idx    <= '0;
            op         <= OP_READ;
            timer      <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_dout     <= '0;
            r_err      <= 1'b0;
            cache_ren  <= 1'b0;
            cache_wen  <= 1'b0;
            cache_addr <= '0;
            cache_din  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            last       <= last_nxt;
            gnt_idx    <= gnt_idx_nxt;
            op         <= op_nxt;
            timer      <= timer_nxt;
            r_gnt      <= r_gnt_nxt;
            r_done     <= r_done_nxt;
            r_dout     <= r_dout_nxt;
            r_err      <= r_err_nxt;
            cache_ren  <= cache_ren_nxt;
            cache_wen  <= cache_wen_nxt;
            cache_addr <= cache_addr_nxt;
            cache_din  <= cache_din_nxt;
            busy       <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_nxt       = last;
        gnt_idx_nxt    = gnt_idx;
        op_nxt         = op;
        timer_nxt      = timer;
        r_gnt_nxt      = r_gnt;
        r_done_nxt     = r_done;
        r_dout_nxt     = r_dout;
        r_err_nxt      = r_err;
        cache_ren_nxt  = cache_ren;
        cache_wen_nxt  = cache_wen;
        cache_addr_nxt = cache_addr;
        cache_din_nxt  = cache_din;
        busy_nxt       = busy;

        case (state)
            IDLE: begin
                if (cache_rdy && pick_valid) begin
                    gnt_idx_nxt    = pick_idx;
                    op_nxt         = r_wen[pick_idx] ? OP_WRITE : OP_READ;
                    cache_addr_nxt = r_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    cache_din_nxt  = r_din[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                    r_gnt_nxt      = idx_to_onehot(pick_idx);
                    cache_wen_nxt  = (op_nxt == OP_WRITE);
                    cache_ren_nxt  = (op_nxt == OP_READ);
                    busy_nxt       = 1'b1;
                    state_nxt      = ISSUE;
                end
            end
            ISSUE: begin
                cache_ren_nxt = 1'b0;
                cache_wen_nxt = 1'b0;
                timer_nxt     = '0;
                state_nxt     = WAIT;
            end
            WAIT: begin
                timer_nxt = timer + 1'b1;
                // a response arriving on the timeout cycle still counts as good
                if (cache_valid) begin
                    r_dout_nxt = cache_dout;
                    r_done_nxt = r_gnt;
                    r_err_nxt  = 1'b0;
                    state_nxt  = RESP;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    r_dout_nxt = '0;
                    r_done_nxt = r_gnt;
                    r_err_nxt  = 1'b1;
                    state_nxt  = RESP;
                end
            end
            RESP: begin
                r_done_nxt = '0;
                r_err_nxt  = 1'b0;
                r_gnt_nxt  = '0;
                last_nxt   = gnt_idx;
                busy_nxt   = 1'b0;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized scoreboard bench for cache_arbiter: requester/cache models drive the
// DUT, a transaction-level model predicts grant order, a monitor checks responses.
module tb_cache_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int T  = 8;
    localparam int K_NORMAL = 0;
    localparam int K_TMO    = 1;
    localparam int K_NONE   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    r_ren, r_wen;
    logic [2*AW-1:0] r_addr;
    logic [2*DW-1:0] r_din;
    logic [1:0]    r_gnt, r_done;
    logic [DW-1:0] r_dout;
    logic          r_err;
    logic          cache_rdy, cache_valid;
    logic [DW-1:0] cache_dout;
    logic          cache_ren, cache_wen;
    logic [AW-1:0] cache_addr;
    logic [DW-1:0] cache_din;
    logic          busy;

    always #5 clk = ~clk;

    cache_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .r_ren(r_ren), .r_wen(r_wen), .r_addr(r_addr), .r_din(r_din),
        .r_gnt(r_gnt), .r_done(r_done), .r_dout(r_dout), .r_err(r_err),
        .cache_rdy(cache_rdy), .cache_valid(cache_valid), .cache_dout(cache_dout),
        .cache_ren(cache_ren), .cache_wen(cache_wen), .cache_addr(cache_addr),
        .cache_din(cache_din), .busy(busy)
    );

    typedef struct {
        bit ren; bit wen; logic [AW-1:0] addr; logic [DW-1:0] din;
        int kind; int k; logic [DW-1:0] data;
    } txn_t;
    typedef struct { logic [1:0] mask; bit wr; logic [AW-1:0] addr; logic [DW-1:0] din; } iss_t;
    typedef struct { logic [1:0] mask; logic [DW-1:0] data; bit err; int lat; } rsp_t;
    typedef struct { int kind; int k; logic [DW-1:0] data; } plan_t;

    txn_t  stg[2][$];
    txn_t  rq[2][$];
    bit    active[2];
    iss_t  exp_iss[$];
    rsp_t  exp_rsp[$];
    plan_t plans[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_cyc = 0;
    int strobe_cnt = 0;
    bit last_m = 1'b1;
    bit rdy_hold = 1'b0;
    int cd = 0;
    logic [DW-1:0] vdata = '0;
    iss_t  mi;
    rsp_t  mr;
    plan_t cp;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    function automatic txn_t mk(input bit ren, input bit wen, input logic [AW-1:0] addr,
                                input logic [DW-1:0] din, input int kind, input int k,
                                input logic [DW-1:0] data);
        txn_t t;
        t.ren = ren; t.wen = wen; t.addr = addr; t.din = din;
        t.kind = kind; t.k = k; t.data = data;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        int r, s;
        r = $urandom_range(0, 2);
        s = $urandom_range(0, 9);
        if (s < 6)      return mk(r != 1, r != 0, $urandom, $urandom, K_NORMAL, $urandom_range(1, 5), $urandom);
        else if (s < 8) return mk(r != 1, r != 0, $urandom, $urandom, K_NORMAL, T, $urandom);
        else            return mk(r != 1, r != 0, $urandom, $urandom, K_TMO, 0, $urandom);
    endfunction

    // Expected issue/response for one granted transaction.
    function automatic void push_expect(input bit w, input txn_t t);
        iss_t  e;
        rsp_t  r;
        plan_t p;
        e.mask = 2'b01 << w; e.wr = t.wen; e.addr = t.addr; e.din = t.din;
        exp_iss.push_back(e);
        p.kind = t.kind; p.k = t.k; p.data = t.data;
        plans.push_back(p);
        if (t.kind != K_NONE) begin
            r.mask = e.mask;
            r.err  = (t.kind == K_TMO);
            r.data = r.err ? '0 : t.data;
            r.lat  = r.err ? T + 1 : t.k + 1;
            exp_rsp.push_back(r);
        end
    endfunction

    // Round-robin order: each requester serves its list in order; when both
    // still have work, the one not served last goes next.
    task automatic schedule();
        int n0, n1, i0, i1;
        bit w;
        n0 = stg[0].size(); n1 = stg[1].size(); i0 = 0; i1 = 0;
        while (i0 < n0 || i1 < n1) begin
            if (i0 < n0 && i1 < n1) w = !last_m;
            else                    w = (i1 < n1);
            if (w) begin push_expect(1'b1, stg[1][i1]); i1++; end
            else   begin push_expect(1'b0, stg[0][i0]); i0++; end
            last_m = w;
        end
        while (stg[0].size() > 0) rq[0].push_back(stg[0].pop_front());
        while (stg[1].size() > 0) rq[1].push_back(stg[1].pop_front());
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((rq[0].size() > 0 || rq[1].size() > 0 || exp_rsp.size() > 0 || exp_iss.size() > 0)
               && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail({name, "_drain_timeout"});
        repeat (3) @(negedge clk);
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_idle_gnt"}, r_gnt, 0);
    endtask

    task automatic wait_strobe(input string name);
        int s, n;
        s = strobe_cnt; n = 0;
        while (strobe_cnt == s && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail({name, "_strobe_timeout"});
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // requester models: hold request until own r_done, then load the next one
    initial begin
        r_ren = '0; r_wen = '0; r_addr = '0; r_din = '0;
        active[0] = 1'b0; active[1] = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rq[0].delete(); rq[1].delete();
                active[0] = 1'b0; active[1] = 1'b0;
                r_ren = '0; r_wen = '0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (r_done[i] && active[i]) begin
                        void'(rq[i].pop_front());
                        active[i] = 1'b0;
                    end
                    if (!active[i] && rq[i].size() > 0) begin
                        r_ren[i] = rq[i][0].ren;
                        r_wen[i] = rq[i][0].wen;
                        r_addr[i*AW +: AW] = rq[i][0].addr;
                        r_din[i*DW +: DW]  = rq[i][0].din;
                        active[i] = 1'b1;
                    end else if (!active[i]) begin
                        r_ren[i] = 1'b0;
                        r_wen[i] = 1'b0;
                    end
                end
            end
        end
    end

    // cache model: random back-pressure, response k cycles after the strobe
    initial begin
        cache_rdy = 1'b0; cache_valid = 1'b0; cache_dout = '0;
        forever begin
            @(negedge clk);
            cache_valid = 1'b0;
            cache_dout  = $urandom;
            cache_rdy   = rdy_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (rst) begin
                cd = 0;
                plans.delete();
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        cache_valid = 1'b1;
                        cache_dout  = vdata;
                    end
                end
                if ((cache_ren || cache_wen) && plans.size() > 0) begin
                    cp = plans.pop_front();
                    vdata = cp.data;
                    // a timed-out transaction gets a late stray response that must be ignored
                    cd = (cp.kind == K_NORMAL) ? cp.k : (cp.kind == K_TMO) ? T + 1 : 0;
                end
            end
        end
    end

    // monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (cache_ren || cache_wen) begin
                    strobe_cnt++;
                    strobe_cyc = cyc;
                    if (exp_iss.size() == 0) fail("unexpected_strobe");
                    else begin
                        mi = exp_iss.pop_front();
                        check("strobe_ren", cache_ren, !mi.wr);
                        check("strobe_wen", cache_wen, mi.wr);
                        check("cache_addr", cache_addr, mi.addr);
                        check("cache_din", cache_din, mi.din);
                        check("gnt_at_issue", r_gnt, mi.mask);
                        check("busy_at_issue", busy, 1);
                    end
                end
                if (r_done != 2'b00) begin
                    if (exp_rsp.size() == 0) fail("unexpected_done");
                    else begin
                        mr = exp_rsp.pop_front();
                        check("r_done", r_done, mr.mask);
                        check("gnt_at_done", r_gnt, mr.mask);
                        check("r_dout", r_dout, mr.data);
                        check("r_err", r_err, mr.err);
                        check("done_latency", cyc - strobe_cyc, mr.lat);
                    end
                end
            end
        end
    end

    initial begin
        int n0, n1;
        rst = 1'b1;
        #12;
        check("rst_gnt", r_gnt, 0);
        check("rst_done", r_done, 0);
        check("rst_dout", r_dout, 0);
        check("rst_err", r_err, 0);
        check("rst_ren", cache_ren, 0);
        check("rst_wen", cache_wen, 0);
        check("rst_addr", cache_addr, 0);
        check("rst_din", cache_din, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #2;

        stg[0].push_back(mk(1, 0, 32'h0000_1040, 32'h0, K_NORMAL, 3, 32'hDEAD_BEEF));
        schedule();
        drain("single_read");

        for (int i = 0; i < 4; i++) begin
            stg[0].push_back(mk(1, 0, $urandom, $urandom, K_NORMAL, 1, $urandom));
            stg[1].push_back(mk(1, 0, $urandom, $urandom, K_NORMAL, 1, $urandom));
        end
        schedule();
        drain("contention");

        stg[1].push_back(mk(0, 1, 32'h0000_2000, 32'h1234_5678, K_NORMAL, 4, $urandom));
        schedule();
        wait_strobe("mix");
        @(negedge clk);
        check("mix_gnt_in_wait", r_gnt, 2'b10);
        stg[0].push_back(mk(1, 0, $urandom, $urandom, K_NORMAL, 2, $urandom));
        schedule();
        drain("mix");

        stg[0].push_back(mk(1, 0, $urandom, $urandom, K_TMO, 0, $urandom));
        stg[0].push_back(mk(1, 0, $urandom, $urandom, K_NORMAL, 2, $urandom));
        schedule();
        drain("timeout");

        rdy_hold = 1'b1;
        @(negedge clk);
        @(posedge clk); #2;
        stg[0].push_back(mk(1, 0, $urandom, $urandom, K_NORMAL, 2, $urandom));
        schedule();
        repeat (5) begin
            @(negedge clk); #1;
            check("bp_ren", cache_ren, 0);
            check("bp_busy", busy, 0);
        end
        rdy_hold = 1'b0;
        drain("backpressure");

        stg[1].push_back(mk(1, 0, $urandom, $urandom, K_NORMAL, T, $urandom));
        schedule();
        drain("race");

        for (int r = 0; r < 12; r++) begin
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 == 0 && n1 == 0) n0 = 1;
            for (int i = 0; i < n0; i++) stg[0].push_back(rand_txn());
            for (int i = 0; i < n1; i++) stg[1].push_back(rand_txn());
            schedule();
            drain("random");
        end

        stg[0].push_back(mk(1, 0, $urandom, $urandom, K_NORMAL, 2, $urandom));
        schedule();
        drain("pre_reset");
        stg[1].push_back(mk(1, 0, $urandom, $urandom, K_NONE, 0, $urandom));
        schedule();
        wait_strobe("reset");
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_ren", cache_ren, 0);
        check("arst_wen", cache_wen, 0);
        check("arst_gnt", r_gnt, 0);
        check("arst_busy", busy, 0);
        check("arst_done", r_done, 0);
        #3 rst = 1'b0;
        last_m = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no_done_after_rst", r_done, 0);
        end
        stg[0].push_back(mk(1, 0, $urandom, $urandom, K_NORMAL, 1, $urandom));
        stg[1].push_back(mk(1, 0, $urandom, $urandom, K_NORMAL, 1, $urandom));
        schedule();
        drain("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single core-side port of the cache between requester 0 (instruction fetch) and requester 1 (load/store unit).
- Sits between the core and the cache and sequences one transaction at a time: select, issue, wait, respond.
- A response-timeout watchdog keeps a requester from hanging on a lost response.

Parameters:
DATA_WIDTH, 32, width of the data bus
ADDR_WIDTH, 32, width of the address bus
TIMEOUT, 64, number of WAIT cycles without cache_valid before the transaction is aborted (must be >= 2)

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  asynchronous, active-high reset
r_ren  input  2  read request; bit i belongs to requester i
r_wen  input  2  write request; bit i belongs to requester i
r_addr  input  2*ADDR_WIDTH  requester i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
r_din  input  2*DATA_WIDTH  requester i write data at [i*DATA_WIDTH +: DATA_WIDTH]
r_gnt  output  2  one-hot; high from ISSUE through RESP for the granted requester
r_done  output  2  one-cycle completion pulse for the granted requester
r_dout  output  DATA_WIDTH  read data; valid while r_done is high
r_err  output  1  high with r_done when the transaction timed out
cache_rdy  input  1  cache can accept a transaction
cache_valid  input  1  one-cycle response strobe from the cache
cache_dout  input  DATA_WIDTH  cache read data; valid with cache_valid
cache_ren  output  1  read strobe to the cache
cache_wen  output  1  write strobe to the cache
cache_addr  output  ADDR_WIDTH  address to the cache
cache_din  output  DATA_WIDTH  write data to the cache
busy  output  1  high whenever state != IDLE

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high. All outputs are registered.
- Reset values:
  - all outputs 0; state = IDLE.
  - Round-robin pointer last = 1, so requester 0 wins the first tie.
  - Timer = 0.
- A requester is pending when r_ren[i] | r_wen[i]. If both are set, the transaction is a write.
- Requester hold rule: addr, din and op must stay stable until r_done. Dropping the request after grant does not abort the transaction.
- IDLE:
  - If cache_rdy and at least one request is pending: pick a requester.
  - With one pending, that one wins. With both pending, the one != last wins.
  - Latch addr, din and op into cache_addr, cache_din and an op register.
  - Set r_gnt to the winner, set cache_ren or cache_wen, go to ISSUE.
  - If cache_rdy = 0, there is no grant.
- ISSUE (exactly 1 cycle; the strobe is high only in this cycle):
  - Clear cache_ren/cache_wen, clear the timer, go to WAIT.
- WAIT:
  - The timer increments each cycle.
  - If cache_valid: r_dout <= cache_dout (writes also forward cache_dout), r_done[g] <= 1, r_err <= 0, go to RESP.
  - Else if timer == TIMEOUT-1: r_dout <= 0, r_done[g] <= 1, r_err <= 1, go to RESP.
  - If cache_valid and the timeout occur in the same cycle, cache_valid wins (r_err = 0).
- RESP (1 cycle):
  - r_done and r_gnt are high this cycle.
  - On exit: clear r_done, r_err and r_gnt, set last <= g, go to IDLE.
  - RESP exists so the requester can deassert or change its request before IDLE resamples it.
- Latency, in edges, from the IDLE sample edge E:
  - cache_ren is high between E and E+1.
  - If the cache sets cache_valid at edge E+1+k, r_done is high between E+1+k and E+2+k.
  - Next possible grant is at edge E+3+k.
- cache_valid outside WAIT is ignored.
- cache_rdy is sampled only in IDLE.
- Reset asserted mid-transaction:
  - All outputs clear immediately and asynchronously. No r_done is emitted.
  - The in-flight cache operation is abandoned; the cache is reset alongside.
- Timer width is $clog2(TIMEOUT+1) and it never wraps within one WAIT.

Decomposition:
- Package cache_arb_pkg holds:
  - NUM_REQ = 2
  - typedef enum {IDLE, ISSUE, WAIT, RESP} arb_state_t
  - typedef logic [0:0] req_idx_t
  - typedef enum {OP_READ, OP_WRITE} arb_op_t
- One sub-module, rr_pick: combinational. Inputs are the 2-bit pending vector and last. Outputs are a valid bit and the winner index. It is kept separate so the policy can be widened to N requesters later.

Test Plan:
- Single read: r_ren = 2'b01, addr0 = 0x0000_1040, cache_valid 3 cycles after the strobe with dout = 0xDEAD_BEEF -> exactly one cache_ren cycle with cache_addr = 0x1040; r_done = 01, r_dout = 0xDEAD_BEEF, r_err = 0.
- Contention: both requesters reading continuously, cache responding after 1 cycle -> grants alternate 0, 1, 0, 1; neither requester is served twice in a row; each r_done carries its own data.
- Write/read mix: req1 write addr 0x2000, din 0x1234_5678, while req0 is idle -> cache_wen = 1, cache_din = 0x1234_5678; req0 arriving mid-WAIT is granted only after RESP.
- Timeout: TIMEOUT = 8, cache never sends cache_valid -> r_done pulses exactly 8 cycles after WAIT entry with r_err = 1 and r_dout = 0; the next request proceeds normally.
- Back-pressure and race: cache_rdy = 0 for 5 cycles with a pending request -> no strobe and busy = 0; separately, cache_valid on the same edge as the timeout -> r_err = 0 and data is returned.
- Async reset during WAIT: rst pulsed mid-cycle -> cache_ren, cache_wen, r_gnt and busy go low before the next edge; no r_done; the first grant after reset goes to requester 0 when both request.
